magia_fixture: RTL and testbench

- Synthesizable boot/end-of-computation (EOC) controller for the MAGIA tile mesh, used in the mesh simulation environment.
- Latches a boot address and releases fetch-enable to all tiles on a run command.
- Collects a 16-bit exit code per tile and reports one aggregated N_TILES*16-bit exit code with pass/fail once every tile has signalled EOC.

---
 rtl/magia_fixture_pkg.sv | 24 ++
 rtl/magia_fixture_eoc_collector.sv | 59 +++++
 rtl/magia_fixture.sv | 179 +++++++++++++++++
 tb/tb_magia_fixture.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/magia_fixture_pkg.sv
// Shared constants, FSM state type and exit-code vector type for the MAGIA
// boot/EOC fixture.
package magia_fixture_pkg;

    localparam int unsigned N_TILES_DEF = 4;
    localparam int unsigned EXIT_W      = 16;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned TIMER_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CONFIGURED = 2'd1,
        ST_RUNNING    = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    typedef logic [N_TILES_DEF*EXIT_W-1:0] exit_vec_t;

    // Tiles fetch from word-aligned addresses only.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/magia_fixture_eoc_collector.sv
// Per-tile sticky EOC tracking and first-exit-code capture.
// FILL_CODE is what a slice reads before its tile has reported.
module magia_fixture_eoc_collector
    import magia_fixture_pkg::*;
#(
    parameter int unsigned       N_TILES   = N_TILES_DEF,
    parameter logic [EXIT_W-1:0] FILL_CODE = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        enable_i,
    input  logic [N_TILES-1:0]          eoc_i,
    input  logic [N_TILES*EXIT_W-1:0]   code_i,
    output logic [N_TILES-1:0]          seen_o,
    output logic [N_TILES*EXIT_W-1:0]   codes_o,
    output logic                        all_done_o
);

    logic [N_TILES-1:0]        seen_q, seen_d;
    logic [N_TILES*EXIT_W-1:0] codes_q, codes_d;
    logic                      all_done_q, all_done_d;

    // First EOC of each tile sets its sticky bit and freezes its code.
    always_comb begin
        seen_d  = seen_q;
        codes_d = codes_q;
        if (start_i) begin
            seen_d  = '0;
            codes_d = {N_TILES{FILL_CODE}};
        end else if (enable_i) begin
            for (int unsigned i = 0; i < N_TILES; i++) begin
                if (eoc_i[i] && !seen_q[i]) begin
                    seen_d[i]                   = 1'b1;
                    codes_d[i*EXIT_W +: EXIT_W] = code_i[i*EXIT_W +: EXIT_W];
                end
            end
        end
        all_done_d = &seen_d;
    end

    // Collector state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seen_q     <= '0;
            codes_q    <= '0;
            all_done_q <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            codes_q    <= codes_d;
            all_done_q <= all_done_d;
        end
    end

    assign seen_o     = seen_q;
    assign codes_o    = codes_q;
    assign all_done_o = all_done_q;

endmodule

// File: rtl/magia_fixture.sv
// Boot / end-of-computation controller for the MAGIA tile mesh.
// Optional watchdog enabled by defining MAGIA_FIXTURE_TIMEOUT_EN.
module magia_fixture
    import magia_fixture_pkg::*;
#(
    parameter int unsigned N_TILES        = N_TILES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        init_i,
    input  logic [ADDR_W-1:0]           boot_addr_i,
    input  logic                        run_i,
    input  logic                        clear_i,
    input  logic [N_TILES-1:0]          tile_eoc_i,
    input  logic [N_TILES*EXIT_W-1:0]   tile_exit_code_i,
    output logic [ADDR_W-1:0]           tile_boot_addr_o,
    output logic [N_TILES-1:0]          tile_fetch_en_o,
    output logic                        busy_o,
    output logic                        eoc_o,
    output logic [N_TILES*EXIT_W-1:0]   exit_code_o,
    output logic                        fail_o,
    output logic                        timeout_o
);

    // Reject degenerate configurations at elaboration.
    if (N_TILES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("magia_fixture: N_TILES and TIMEOUT_CYCLES must be >= 1");
    end

`ifdef MAGIA_FIXTURE_TIMEOUT_EN
    localparam logic [EXIT_W-1:0] FillCode = '1;
`else
    localparam logic [EXIT_W-1:0] FillCode = '0;
`endif

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         boot_q, boot_d;
    logic [N_TILES-1:0]        fetch_en_q, fetch_en_d;
    logic                      busy_q, busy_d;
    logic                      eoc_q, eoc_d;
    logic                      fail_q, fail_d;
    logic                      timeout_q, timeout_d;
    logic                      start_c;
    logic                      timeout_hit_c;
    logic [N_TILES-1:0]        eoc_seen;
    logic [N_TILES*EXIT_W-1:0] exit_codes;
    logic                      all_done;

    magia_fixture_eoc_collector #(
        .N_TILES   (N_TILES),
        .FILL_CODE (FillCode)
    ) u_collector (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_c),
        .enable_i   (state_q == ST_RUNNING),
        .eoc_i      (tile_eoc_i),
        .code_i     (tile_exit_code_i),
        .seen_o     (eoc_seen),
        .codes_o    (exit_codes),
        .all_done_o (all_done)
    );

`ifdef MAGIA_FIXTURE_TIMEOUT_EN
    logic [TIMER_W-1:0] timer_q, timer_d;

    // Watchdog counts RUNNING cycles from zero at run start.
    always_comb begin
        timer_d = timer_q;
        if (start_c) begin
            timer_d = '0;
        end else if (state_q == ST_RUNNING) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    assign timeout_hit_c = (state_q == ST_RUNNING) &&
                           (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_hit_c = 1'b0;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        boot_d     = boot_q;
        fetch_en_d = '0;
        busy_d     = 1'b0;
        eoc_d      = 1'b0;
        fail_d     = 1'b0;
        timeout_d  = 1'b0;
        start_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_i) begin
                    boot_d  = align_word(boot_addr_i);
                    state_d = ST_CONFIGURED;
                end
            end
            ST_CONFIGURED: begin
                if (init_i) begin
                    boot_d = align_word(boot_addr_i);
                end
                if (run_i) begin
                    start_c    = 1'b1;
                    fetch_en_d = '1;
                    busy_d     = 1'b1;
                    state_d    = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (all_done) begin
                    eoc_d   = 1'b1;
                    fail_d  = |exit_codes;
                    state_d = ST_DONE;
                end else if (timeout_hit_c) begin
                    eoc_d     = 1'b1;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    // A tile loses fetch enable as soon as its EOC is captured.
                    fetch_en_d = ~(eoc_seen | tile_eoc_i);
                    busy_d     = 1'b1;
                end
            end
            ST_DONE: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end else begin
                    eoc_d     = 1'b1;
                    fail_d    = fail_q;
                    timeout_d = timeout_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            boot_q     <= '0;
            fetch_en_q <= '0;
            busy_q     <= 1'b0;
            eoc_q      <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_q     <= boot_d;
            fetch_en_q <= fetch_en_d;
            busy_q     <= busy_d;
            eoc_q      <= eoc_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tile_boot_addr_o = boot_q;
    assign tile_fetch_en_o  = fetch_en_q;
    assign busy_o           = busy_q;
    assign eoc_o            = eoc_q;
    assign exit_code_o      = exit_codes;
    assign fail_o           = fail_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_magia_fixture.sv
// Self-checking bench for magia_fixture; DONE results scored from a queue.
module tb_magia_fixture;

    localparam int unsigned NT = 4;
    localparam int unsigned EW = 16;
    localparam int unsigned CW = NT * EW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          init_i;
    logic [31:0]   boot_addr_i;
    logic          run_i;
    logic          clear_i;
    logic [NT-1:0] tile_eoc_i;
    logic [CW-1:0] tile_exit_code_i;
    logic [31:0]   tile_boot_addr_o;
    logic [NT-1:0] tile_fetch_en_o;
    logic          busy_o;
    logic          eoc_o;
    logic [CW-1:0] exit_code_o;
    logic          fail_o;
    logic          timeout_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CW-1:0] code;
        logic          fail;
        logic          tmo;
    } exp_t;

    exp_t sb[$];

    magia_fixture #(
        .N_TILES        (NT),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .init_i           (init_i),
        .boot_addr_i      (boot_addr_i),
        .run_i            (run_i),
        .clear_i          (clear_i),
        .tile_eoc_i       (tile_eoc_i),
        .tile_exit_code_i (tile_exit_code_i),
        .tile_boot_addr_o (tile_boot_addr_o),
        .tile_fetch_en_o  (tile_fetch_en_o),
        .busy_o           (busy_o),
        .eoc_o            (eoc_o),
        .exit_code_o      (exit_code_o),
        .fail_o           (fail_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: each rising eoc_o consumes one expected result.
    logic eoc_prev = 1'b0;
    always @(negedge clk_i) begin
        if (eoc_o === 1'b1 && eoc_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_done: eoc_o rose with no expected result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (exit_code_o !== e.code) begin
                    errors++;
                    $display("FAIL sb_exit_code: got %h expected %h", exit_code_o, e.code);
                end
                checks++;
                if (fail_o !== e.fail) begin
                    errors++;
                    $display("FAIL sb_fail: got %b expected %b", fail_o, e.fail);
                end
                checks++;
                if (timeout_o !== e.tmo) begin
                    errors++;
                    $display("FAIL sb_timeout: got %b expected %b", timeout_o, e.tmo);
                end
            end
        end
        eoc_prev = eoc_o;
    end

    task automatic do_init(input logic [31:0] addr);
        init_i = 1'b1; boot_addr_i = addr;
        step();
        init_i = 1'b0;
    endtask

    task automatic do_run();
        run_i = 1'b1;
        step();
        run_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        checks++;
        if ({tile_boot_addr_o, tile_fetch_en_o, busy_o, eoc_o, fail_o, timeout_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got addr=%h en=%b busy=%b eoc=%b fail=%b to=%b expected all 0",
                     tile_boot_addr_o, tile_fetch_en_o, busy_o, eoc_o, fail_o, timeout_o);
        end
        checks++;
        if (exit_code_o !== '0) begin
            errors++;
            $display("FAIL reset_exit: got %h expected 0", exit_code_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_ignore();
        // run and tile EOCs in IDLE must not start anything
        run_i = 1'b1; tile_eoc_i = '1;
        step();
        run_i = 1'b0;
        step();
        checks++;
        if (busy_o !== 1'b0 || tile_fetch_en_o !== 4'b0000 || eoc_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got busy=%b en=%b eoc=%b expected 0/0000/0",
                     busy_o, tile_fetch_en_o, eoc_o);
        end
        do_init(32'hCC00_0002);
        step();
        checks++;
        if (busy_o !== 1'b0 || tile_fetch_en_o !== 4'b0000 || eoc_o !== 1'b0) begin
            errors++;
            $display("FAIL cfg_eoc_ignore: got busy=%b en=%b eoc=%b expected 0/0000/0",
                     busy_o, tile_fetch_en_o, eoc_o);
        end
        tile_eoc_i = '0;
    endtask

    task automatic test_basic();
        int            sched[NT] = '{5, 9, 9, 20};
        logic [NT-1:0] seen = '0;
        logic [NT-1:0] exp_en;
        do_init(32'hCC00_0002);
        checks++;
        if (tile_boot_addr_o !== 32'hCC00_0000) begin
            errors++;
            $display("FAIL basic_boot_addr: got %h expected cc000000", tile_boot_addr_o);
        end
        sb.push_back('{code: 64'h0, fail: 1'b0, tmo: 1'b0});
        do_run();
        for (int cyc = 1; cyc <= 22; cyc++) begin
            exp_en = (cyc <= 21) ? ~seen : 4'b0000;
            checks++;
            if (tile_fetch_en_o !== exp_en || busy_o !== (cyc <= 21) || eoc_o !== (cyc == 22)) begin
                errors++;
                $display("FAIL basic_cycle%0d: got en=%b busy=%b eoc=%b expected en=%b busy=%b eoc=%b",
                         cyc, tile_fetch_en_o, busy_o, eoc_o, exp_en, cyc <= 21, cyc == 22);
            end
            for (int i = 0; i < NT; i++) begin
                tile_eoc_i[i] = (sched[i] == cyc);
                tile_exit_code_i[i*EW +: EW] = tile_eoc_i[i] ? 16'h0000 : 16'($urandom);
            end
            step();
            seen = seen | tile_eoc_i;
        end
        tile_eoc_i = '0;
        do_clear();
        checks++;
        if (eoc_o !== 1'b0 || busy_o !== 1'b0 || fail_o !== 1'b0 ||
            tile_boot_addr_o !== 32'hCC00_0000) begin
            errors++;
            $display("FAIL basic_clear: got eoc=%b busy=%b fail=%b addr=%h expected 0/0/0/cc000000",
                     eoc_o, busy_o, fail_o, tile_boot_addr_o);
        end
    endtask

    task automatic test_sticky();
        int n = 0;
        do_init(32'h1234_5677);
        checks++;
        if (tile_boot_addr_o !== 32'h1234_5674) begin
            errors++;
            $display("FAIL sticky_boot_addr: got %h expected 12345674", tile_boot_addr_o);
        end
        // init and run together: run wins, address still latched
        init_i = 1'b1; run_i = 1'b1; boot_addr_i = 32'hABCD_EF03;
        step();
        init_i = 1'b0; run_i = 1'b0;
        checks++;
        if (tile_boot_addr_o !== 32'hABCD_EF00 || busy_o !== 1'b1 || tile_fetch_en_o !== 4'b1111) begin
            errors++;
            $display("FAIL init_run_same: got addr=%h busy=%b en=%b expected abcdef00/1/1111",
                     tile_boot_addr_o, busy_o, tile_fetch_en_o);
        end
        sb.push_back('{code: 64'h0000_00AB_0000_0000, fail: 1'b1, tmo: 1'b0});
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tile_eoc_i = '0;
            tile_exit_code_i = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            if (cyc == 2) begin tile_eoc_i[2] = 1'b1; tile_exit_code_i[47:32] = 16'h00AB; end
            if (cyc == 4) begin tile_eoc_i[2] = 1'b1; tile_exit_code_i[47:32] = 16'h0001; end
            if (cyc == 6) begin
                tile_eoc_i = 4'b1011;
                tile_exit_code_i[15:0] = 16'h0; tile_exit_code_i[31:16] = 16'h0;
                tile_exit_code_i[63:48] = 16'h0;
            end
            step();
        end
        tile_eoc_i = '0;
        while (eoc_o !== 1'b1 && n < 10) begin step(); n++; end
        checks++;
        if (eoc_o !== 1'b1) begin
            errors++;
            $display("FAIL sticky_done_wait: got eoc=%b expected 1 within 10 cycles", eoc_o);
        end
        step();
        do_clear();
    endtask

    task automatic test_back_to_back();
        do_init(32'h0000_1000);
        sb.push_back('{code: 64'h8000_0000_0000_0001, fail: 1'b1, tmo: 1'b0});
        do_run();
        step(); step();
        tile_eoc_i = '1;
        tile_exit_code_i = 64'h8000_0000_0000_0001;
        step();
        tile_eoc_i = '0;
        tile_exit_code_i = '0;
        checks++;
        if (eoc_o !== 1'b0 || busy_o !== 1'b1 || tile_fetch_en_o !== 4'b0000) begin
            errors++;
            $display("FAIL same_cycle_plus1: got eoc=%b busy=%b en=%b expected 0/1/0000",
                     eoc_o, busy_o, tile_fetch_en_o);
        end
        step();
        checks++;
        if (eoc_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_plus2: got eoc=%b busy=%b expected 1/0", eoc_o, busy_o);
        end
        // EOCs while DONE change nothing
        tile_eoc_i = '1; tile_exit_code_i = '1;
        step();
        tile_eoc_i = '0;
        do_clear();
        checks++;
        if (eoc_o !== 1'b0 || fail_o !== 1'b0 || exit_code_o !== 64'h8000_0000_0000_0001) begin
            errors++;
            $display("FAIL same_cycle_clear: got eoc=%b fail=%b exit=%h expected 0/0/8000000000000001",
                     eoc_o, fail_o, exit_code_o);
        end
        // run in IDLE after clear stays ignored
        do_run();
        checks++;
        if (busy_o !== 1'b0 || tile_fetch_en_o !== 4'b0000) begin
            errors++;
            $display("FAIL post_clear_run: got busy=%b en=%b expected 0/0000", busy_o, tile_fetch_en_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        do_init(32'h2000_0000);
        do_run();
        step();
        tile_eoc_i = 4'b0011; tile_exit_code_i = 64'h0000_0000_0006_0005;
        step();
        tile_eoc_i = '0;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++;
        if ({tile_boot_addr_o, tile_fetch_en_o, busy_o, eoc_o, fail_o, timeout_o} !== '0 ||
            exit_code_o !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got addr=%h en=%b busy=%b eoc=%b exit=%h fail=%b expected all 0",
                     tile_boot_addr_o, tile_fetch_en_o, busy_o, eoc_o, exit_code_o, fail_o);
        end
        do_init(32'h3000_0004);
        checks++;
        if (tile_boot_addr_o !== 32'h3000_0004) begin
            errors++;
            $display("FAIL midrun_reinit: got %h expected 30000004", tile_boot_addr_o);
        end
        sb.push_back('{code: 64'h0, fail: 1'b0, tmo: 1'b0});
        do_run();
        checks++;
        if (tile_fetch_en_o !== 4'b1111) begin
            errors++;
            $display("FAIL midrun_rerun_en: got %b expected 1111", tile_fetch_en_o);
        end
        tile_eoc_i = '1; tile_exit_code_i = '0;
        step();
        tile_eoc_i = '0;
        while (eoc_o !== 1'b1 && n < 10) begin step(); n++; end
        checks++;
        if (eoc_o !== 1'b1) begin
            errors++;
            $display("FAIL midrun_done_wait: got eoc=%b expected 1 within 10 cycles", eoc_o);
        end
        step();
        do_clear();
    endtask

`ifdef MAGIA_FIXTURE_TIMEOUT_EN
    task automatic test_timeout();
        int cyc = 1;
        do_init(32'h4000_0000);
        sb.push_back('{code: {16'hFFFF, 48'h0}, fail: 1'b1, tmo: 1'b1});
        do_run();
        while (eoc_o !== 1'b1 && cyc < 120) begin
            tile_eoc_i = (cyc == 2) ? 4'b0111 : 4'b0000;
            tile_exit_code_i = '0;
            step();
            cyc++;
        end
        tile_eoc_i = '0;
        checks++;
        if (eoc_o !== 1'b1 || timeout_o !== 1'b1 || cyc != 51) begin
            errors++;
            $display("FAIL timeout_expire: got eoc=%b to=%b at cycle %0d expected 1/1 at cycle 51",
                     eoc_o, timeout_o, cyc);
        end
        step();
        do_clear();
    endtask
`endif

    initial begin
        rst_i = 1'b1; init_i = 1'b0; boot_addr_i = '0; run_i = 1'b0; clear_i = 1'b0;
        tile_eoc_i = '0; tile_exit_code_i = '0;
        test_reset();
        test_ignore();
        test_basic();
        test_sticky();
        test_back_to_back();
        test_reset_mid_run();
`ifdef MAGIA_FIXTURE_TIMEOUT_EN
        test_timeout();
`endif
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
